// File: rtl/conv_row_sched_pkg.sv
// Shared definitions for the conv row-buffer scheduler and the conv layer it feeds.
package conv_row_sched_pkg;

    localparam int NBANK       = 4;
    localparam int CONV_WIDTH  = 1920;
    localparam int CONV_HEIGHT = 1080;
    localparam int CONV_AW     = 11;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        IDLE       = 2'd1,
        BUSY       = 2'd2
    } sched_state_e;

    typedef logic [$clog2(NBANK)-1:0] bank_idx_t;

endpackage

// File: rtl/conv_row_sched_if.sv
// Pixel-source and conv-layer signals of the row scheduler, grouped as one bus.
interface conv_row_sched_if
    import conv_row_sched_pkg::*;
#(
    parameter int AW = CONV_AW
);
    logic             frame_start;
    logic             pix_valid;
    logic             pix_ready;
    logic             wr_en;
    bank_idx_t        wr_bank;
    logic [AW-1:0]    wr_addr;
    logic             conv_start;
    bank_idx_t        conv_base;
    logic             conv_done;
    logic [NBANK-1:0] bank_full;
    logic             frame_done;

    modport master (
        output frame_start, pix_valid, conv_done,
        input  pix_ready, wr_en, wr_bank, wr_addr, conv_start, conv_base, bank_full, frame_done
    );

    modport slave (
        input  frame_start, pix_valid, conv_done,
        output pix_ready, wr_en, wr_bank, wr_addr, conv_start, conv_base, bank_full, frame_done
    );
endinterface

// File: rtl/conv_row_writer.sv
// Write-side pointer of the row ring: column address, bank and rows written this frame.
module conv_row_writer
    import conv_row_sched_pkg::*;
#(
    parameter int WIDTH  = CONV_WIDTH,
    parameter int HEIGHT = CONV_HEIGHT,
    parameter int AW     = CONV_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          wr_en,
    output bank_idx_t     wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          rows_done,
    output logic          row_complete,
    output bank_idx_t     row_bank
);
    bank_idx_t     wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rows_q, rows_d;
    logic          last_col;

    assign last_col     = (wr_addr_q == AW'(WIDTH - 1));
    assign row_complete = wr_en & last_col;
    assign row_bank     = wr_bank_q;
    assign rows_done    = (rows_q == AW'(HEIGHT));
    assign wr_bank      = wr_bank_q;
    assign wr_addr      = wr_addr_q;

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        rows_d    = rows_q;
        if (clr) begin
            wr_bank_d = '0;
            wr_addr_d = '0;
            rows_d    = '0;
        end else if (wr_en) begin
            if (last_col) begin
                wr_addr_d = '0;
                wr_bank_d = wr_bank_q + 2'd1;
                rows_d    = rows_q + AW'(1);
            end else begin
                wr_addr_d = wr_addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q <= '0;
            wr_addr_q <= '0;
            rows_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            rows_q    <= rows_d;
        end
    end

endmodule

// File: rtl/conv_row_sched.sv
// Four-bank row ring scheduler: tracks full banks and launches 3-row conv passes.
module conv_row_sched
    import conv_row_sched_pkg::*;
#(
    parameter int WIDTH  = CONV_WIDTH,
    parameter int HEIGHT = CONV_HEIGHT,
    parameter int AW     = CONV_AW
) (
    input  logic            clk,
    input  logic            reset,
    conv_row_sched_if.slave bus
);
    if (WIDTH < 3 || HEIGHT < 3) begin : g_bad_dims
        $error("conv_row_sched: WIDTH and HEIGHT must both be >= 3");
    end
    if ((2 ** AW) <= WIDTH || (2 ** AW) <= HEIGHT) begin : g_bad_aw
        $error("conv_row_sched: AW too narrow for WIDTH/HEIGHT");
    end

    sched_state_e     state_q, state_d;
    logic [NBANK-1:0] bank_full_q, bank_full_d;
    bank_idx_t        conv_base_q, conv_base_d;
    logic [AW-1:0]    passes_q, passes_d;
    logic             conv_start_q, conv_start_d;
    logic             frame_done_q, frame_done_d;

    logic      rows_done, row_complete, triple_full, frame_end;
    bank_idx_t row_bank;

    conv_row_writer #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .AW    (AW)
    ) u_writer (
        .clk         (clk),
        .reset       (reset),
        .clr         (frame_end),
        .wr_en       (bus.wr_en),
        .wr_bank     (bus.wr_bank),
        .wr_addr     (bus.wr_addr),
        .rows_done   (rows_done),
        .row_complete(row_complete),
        .row_bank    (row_bank)
    );

    // The writer only ever targets a free bank, so a full bank under it means the ring is full.
    assign bus.pix_ready = (state_q != WAIT_FRAME) & ~bank_full_q[bus.wr_bank] & ~rows_done;
    assign bus.wr_en     = bus.pix_valid & bus.pix_ready;

    assign triple_full = bank_full_q[conv_base_q]
                       & bank_full_q[conv_base_q + 2'd1]
                       & bank_full_q[conv_base_q + 2'd2];

    assign frame_end = (state_q == BUSY) & bus.conv_done
                     & ((passes_q + AW'(1)) == AW'(HEIGHT - 2));

    always_comb begin
        state_d      = state_q;
        bank_full_d  = bank_full_q;
        conv_base_d  = conv_base_q;
        passes_d     = passes_q;
        conv_start_d = 1'b0;
        frame_done_d = 1'b0;
        if (row_complete) bank_full_d[row_bank] = 1'b1;
        unique case (state_q)
            WAIT_FRAME: if (bus.frame_start) state_d = IDLE;
            IDLE: begin
                if (triple_full) begin
                    conv_start_d = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (bus.conv_done) begin
                    bank_full_d[conv_base_q] = 1'b0;
                    conv_base_d = conv_base_q + 2'd1;
                    passes_d    = passes_q + AW'(1);
                    state_d     = IDLE;
                    if (frame_end) begin
                        frame_done_d = 1'b1;
                        bank_full_d  = '0;
                        conv_base_d  = '0;
                        passes_d     = '0;
                        state_d      = WAIT_FRAME;
                    end
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_FRAME;
            bank_full_q  <= '0;
            conv_base_q  <= '0;
            passes_q     <= '0;
            conv_start_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_full_q  <= bank_full_d;
            conv_base_q  <= conv_base_d;
            passes_q     <= passes_d;
            conv_start_q <= conv_start_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.conv_start = conv_start_q;
    assign bus.conv_base  = conv_base_q;
    assign bus.bank_full  = bank_full_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_row_sched.sv
// Bench for conv_row_sched: directed scenarios plus random frames against a row-count model.
module tb_conv_row_sched;
    localparam int W  = 4;
    localparam int H  = 5;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_row_sched_if #(.AW(AW)) bus();

    conv_row_sched #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Model state in frame terms: rows written, passes finished, column in the current row.
    int m_armed = 0, m_busy = 0, m_rows = 0, m_col = 0, m_pass = 0, m_start = 0, m_done = 0;

    int n_chk = 0, n_pass = 0;
    int accepts = 0, starts = 0, dones = 0;
    int start_bases[$];
    int cd_timer = 0, auto_resp = 0, resp_dly = 5, rand_dly = 0;
    logic stray_cd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // A bank is full when it holds a row that has been written but not yet consumed.
    function automatic logic [3:0] exp_full();
        logic [3:0] f;
        f = '0;
        for (int r = m_pass; r < m_rows; r++) f[r % 4] = 1'b1;
        return f;
    endfunction

    task automatic clear_stats();
        accepts = 0; starts = 0; dones = 0;
        start_bases.delete();
    endtask

    task automatic model_step(input logic wen);
        if (reset) begin
            m_armed = 0; m_busy = 0; m_rows = 0; m_col = 0; m_pass = 0; m_start = 0; m_done = 0;
            return;
        end
        m_start = 0;
        m_done  = 0;
        if (m_armed == 0) begin
            if (bus.frame_start) m_armed = 1;
        end else if (m_busy == 0) begin
            if (m_rows - m_pass >= 3) begin m_start = 1; m_busy = 1; end
        end else if (bus.conv_done) begin
            m_pass++;
            m_busy = 0;
            if (m_pass == H - 2) begin
                m_done = 1; m_armed = 0; m_rows = 0; m_col = 0; m_pass = 0;
            end
        end
        if (wen) begin
            m_col++;
            if (m_col == W) begin m_col = 0; m_rows++; end
        end
    endtask

    // One clock: drive conv_done, check every output at the falling edge, advance the model.
    task automatic cycle();
        logic rdy, wen, fire;
        fire = 1'b0;
        if (cd_timer > 0) begin
            cd_timer--;
            fire = (cd_timer == 0);
        end
        bus.conv_done = fire | stray_cd;
        @(negedge clk);
        rdy = (m_armed != 0) && (m_rows != H) && (m_rows - m_pass < 4);
        wen = bus.pix_valid && rdy;
        chk("pix_ready",  32'(bus.pix_ready),  32'(rdy));
        chk("wr_en",      32'(bus.wr_en),      32'(wen));
        chk("wr_bank",    32'(bus.wr_bank),    32'(m_rows % 4));
        chk("wr_addr",    32'(bus.wr_addr),    32'(m_col));
        chk("bank_full",  32'(bus.bank_full),  32'(exp_full()));
        chk("conv_base",  32'(bus.conv_base),  32'(m_pass % 4));
        chk("conv_start", 32'(bus.conv_start), 32'(m_start));
        chk("frame_done", 32'(bus.frame_done), 32'(m_done));
        if (bus.wr_en) accepts++;
        if (bus.conv_start) begin
            starts++;
            start_bases.push_back(int'(bus.conv_base));
            if (auto_resp != 0) cd_timer = (rand_dly != 0) ? int'($urandom_range(1, 6)) : resp_dly;
        end
        if (bus.frame_done) dones++;
        model_step(wen);
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
        bus.conv_done   = 1'b0;
        stray_cd        = 1'b0;
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 200 && accepts < n; i++) cycle();
        chk("accept_count", 32'(accepts), 32'(n));
    endtask

    task automatic wait_frame_done(input string tag);
        for (int i = 0; i < 400 && dones == 0; i++) cycle();
        chk(tag, 32'(dones), 32'd1);
    endtask

    task automatic check_passes(input string tag);
        chk(tag, 32'(starts), 32'(H - 2));
        for (int i = 0; i < start_bases.size() && i < H - 2; i++)
            chk("pass_base", 32'(start_bases[i]), 32'(i % 4));
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.conv_done   = 1'b0;
        #1;
        repeat (3) cycle();
        reset = 1'b0;

        // Valid pixels before any frame_start must be refused.
        bus.pix_valid = 1'b1;
        repeat (4) cycle();
        chk("idle_ready", 32'(bus.pix_ready), 32'd0);
        chk("idle_full",  32'(bus.bank_full), 32'd0);
        chk("idle_addr",  32'(bus.wr_addr),   32'd0);
        chk("idle_accepts", 32'(accepts), 32'd0);

        // Three rows fill banks 0..2, conv_start two cycles after the last pixel.
        clear_stats();
        bus.frame_start = 1'b1;
        cycle();
        wait_acc(12);
        chk("full_after_12", 32'(bus.bank_full), 32'b0111);
        cycle();
        chk("start_at_n2", 32'(bus.conv_start), 32'd1);
        chk("start_base0", 32'(bus.conv_base),  32'd0);

        // Withheld conv_done: bank 3 fills and the ring stalls.
        wait_acc(16);
        chk("ring_full",   32'(bus.bank_full), 32'b1111);
        chk("ring_stall",  32'(bus.pix_ready), 32'd0);
        chk("ring_wrbank", 32'(bus.wr_bank),   32'd0);
        repeat (4) cycle();
        chk("stall_no_accept", 32'(accepts), 32'd16);
        stray_cd = 1'b1;
        cycle();
        chk("freed_full",  32'(bus.bank_full), 32'b1110);
        chk("freed_base",  32'(bus.conv_base), 32'd1);
        chk("freed_ready", 32'(bus.pix_ready), 32'd1);
        auto_resp = 1;
        resp_dly  = 5;
        wait_frame_done("frame1_done");
        check_passes("frame1_starts");
        chk("frame1_full",  32'(bus.bank_full), 32'd0);
        chk("frame1_ready", 32'(bus.pix_ready), 32'd0);

        // Clean full frame with conv_done five cycles after each start.
        clear_stats();
        bus.frame_start = 1'b1;
        cycle();
        wait_frame_done("frame2_done");
        check_passes("frame2_starts");
        repeat (6) cycle();
        chk("frame2_single_done", 32'(dones), 32'd1);
        chk("frame2_full", 32'(bus.bank_full), 32'd0);

        // Reset while BUSY, then a stray conv_done.
        auto_resp = 0;
        bus.frame_start = 1'b1;
        cycle();
        for (int i = 0; i < 100 && m_busy == 0; i++) cycle();
        chk("reached_busy", 32'(m_busy), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_stats();
        stray_cd = 1'b1;
        cycle();
        repeat (5) cycle();
        chk("rst_no_start", 32'(starts), 32'd0);
        chk("rst_no_done",  32'(dones),  32'd0);
        chk("rst_full",     32'(bus.bank_full), 32'd0);
        chk("rst_ready",    32'(bus.pix_ready), 32'd0);
        chk("rst_base",     32'(bus.conv_base), 32'd0);

        // Random frames: bursty source, random conv latency, stray inputs, one aborted frame.
        auto_resp = 1;
        rand_dly  = 1;
        for (int f = 0; f < 6; f++) begin
            int abort_at;
            abort_at = (f == 3) ? int'($urandom_range(5, 40)) : -1;
            clear_stats();
            bus.frame_start = 1'b1;
            cycle();
            for (int i = 0; i < 3000 && dones == 0; i++) begin
                bus.pix_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) bus.frame_start = 1'b1;
                if (m_busy == 0 && $urandom_range(0, 9) == 0) stray_cd = 1'b1;
                if (i == abort_at) begin
                    reset = 1'b1;
                    cycle();
                    reset = 1'b0;
                    cd_timer = 0;
                    break;
                end
                cycle();
            end
            if (f != 3) begin
                chk("rand_frame_done", 32'(dones), 32'd1);
                check_passes("rand_starts");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
